// File: rtl/riscv_fetch.sv
// RISC-V instruction fetch: one outstanding imem request, one-entry hold buffer toward decode.
// Latency grant->inst_valid_o is 2 cycles; decode backpressure parks the FSM in S_HOLD with a stable word.
module riscv_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    input  logic        inst_ready_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] fetch_count_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & 32'hFFFF_FFFC;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic [31:0] count_q, count_d;
    logic        drop_q, drop_d;
    logic [31:0] redir_pc;

    assign redir_pc = redirect_pc_i & 32'hFFFF_FFFC;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fetch_pc_d = fetch_pc_q;
        inst_d     = inst_q;
        inst_pc_d  = inst_pc_q;
        count_d    = count_q;
        drop_d     = drop_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
                if (redirect_i) begin
                    pc_d = redir_pc;
                end
            end
            S_REQ: begin
                if (imem_gnt_i) begin
                    fetch_pc_d = pc_q;
                    pc_d       = redirect_i ? redir_pc : pc_q + 32'd4;
                    // A redirect coinciding with the grant makes the granted word stale.
                    drop_d     = redirect_i;
                    state_d    = S_WAIT;
                end else if (redirect_i) begin
                    pc_d = redir_pc;
                end
            end
            S_WAIT: begin
                if (redirect_i) begin
                    pc_d = redir_pc;
                end
                if (imem_rvalid_i) begin
                    drop_d  = 1'b0;
                    state_d = S_REQ;
                    if (!drop_q && !redirect_i) begin
                        inst_d    = imem_rdata_i;
                        inst_pc_d = fetch_pc_q;
                        state_d   = S_HOLD;
                    end
                end else if (redirect_i) begin
                    drop_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (redirect_i) begin
                    pc_d    = redir_pc;
                    state_d = S_REQ;
                end else if (inst_ready_i) begin
                    count_d = count_q + 32'd1;
                    state_d = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC_ALIGNED;
            fetch_pc_q <= 32'd0;
            inst_q     <= 32'd0;
            inst_pc_q  <= 32'd0;
            count_q    <= 32'd0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fetch_pc_q <= fetch_pc_d;
            inst_q     <= inst_d;
            inst_pc_q  <= inst_pc_d;
            count_q    <= count_d;
            drop_q     <= drop_d;
        end
    end

    assign imem_req_o    = (state_q == S_REQ);
    assign imem_addr_o   = (state_q == S_REQ) ? pc_q : 32'd0;
    assign inst_valid_o  = (state_q == S_HOLD) && !redirect_i;
    assign inst_o        = inst_q;
    assign pc_o          = inst_pc_q;
    assign fetch_count_o = count_q;

endmodule

// File: doc/riscv_fetch.md
RISCV_FETCH -- requirements
Module: riscv_fetch

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, address of the first instruction fetched after reset.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 imem_req_o  output  1  instruction-memory request valid.
REQ-005 imem_addr_o  output  32  request word address; bits [1:0] always 0.
REQ-006 imem_gnt_i  input  1  memory accepts the request this cycle when high together with imem_req_o.
REQ-007 imem_rvalid_i  input  1  read data valid; in order, at least 1 cycle after grant, at most one outstanding.
REQ-008 imem_rdata_i  input  32  instruction word returned by memory.
REQ-009 inst_valid_o  output  1  inst_o and pc_o hold a fetched instruction for the decoder.
REQ-010 inst_o  output  32  instruction word to the decoder.
REQ-011 pc_o  output  32  address of inst_o.
REQ-012 inst_ready_i  input  1  downstream consumes inst_o when high with inst_valid_o.
REQ-013 redirect_i  input  1  taken jump/branch; abandon the current fetch.
REQ-014 redirect_pc_i  input  32  redirect target; bits [1:0] ignored and forced to 0.
REQ-015 fetch_count_o  output  32  number of completed inst_valid_o/inst_ready_i handshakes.

Function
REQ-016 The block SHALL use a four-state FSM: S_IDLE, S_REQ, S_WAIT, S_HOLD.
REQ-017 S_IDLE: all outputs inactive; the next state SHALL be S_REQ unconditionally.
REQ-018 S_REQ: imem_req_o=1 and imem_addr_o=pc_q. On grant, the block SHALL load fetch_pc_q<=pc_q, set pc_q<=pc_q+4 and go to S_WAIT. Without grant it stays in S_REQ.
REQ-019 pc_q+4 SHALL wrap modulo 2^32, so 32'hFFFF_FFFC is followed by 32'h0000_0000.
REQ-020 S_WAIT: imem_req_o=0. On imem_rvalid_i with drop_q=0, the block SHALL set inst_q<=imem_rdata_i and inst_pc_q<=fetch_pc_q, then go to S_HOLD.
REQ-021 S_WAIT: on imem_rvalid_i with drop_q=1, the response SHALL be discarded, drop_q cleared, and the FSM SHALL go to S_REQ.
REQ-022 S_HOLD: inst_valid_o = ~redirect_i, inst_o=inst_q, pc_o=inst_pc_q. On inst_ready_i & ~redirect_i, the FSM SHALL go to S_REQ and fetch_count_o SHALL increment (wrapping).
REQ-023 Redirect in S_REQ without grant: pc_q<=redirect_pc_i&~3; the FSM stays in S_REQ.
REQ-024 Redirect in S_REQ with grant in the same cycle: pc_q<=redirect_pc_i&~3, drop_q<=1, and the FSM goes to S_WAIT (the in-flight response is discarded).
REQ-025 Redirect in S_WAIT without rvalid: pc_q<=redirect_pc_i&~3, drop_q<=1, and the FSM stays in S_WAIT.
REQ-026 Redirect in S_WAIT with rvalid in the same cycle: the response SHALL be discarded, pc_q<=redirect_pc_i&~3, drop_q<=0, and the FSM goes to S_REQ.
REQ-027 Redirect in S_HOLD: inst_valid_o=0 that cycle, no handshake is counted, pc_q<=redirect_pc_i&~3, and the FSM goes to S_REQ.
REQ-028 A redirect in S_IDLE SHALL load pc_q; the FSM still proceeds to S_REQ.
REQ-029 imem_rvalid_i outside S_WAIT SHALL be ignored.
REQ-030 Minimum latency from grant to inst_valid_o SHALL be 2 cycles (grant, rvalid, then visible in S_HOLD). Peak throughput is one instruction per 3 cycles.
REQ-031 inst_o and pc_o SHALL stay stable while inst_valid_o=1 and inst_ready_i=0.

Reset
REQ-032 While rst=1: state=S_IDLE, pc_q=RESET_PC, fetch_pc_q=0, inst_q=0, inst_pc_q=0, drop_q=0, fetch_count_o=0, imem_req_o=0, imem_addr_o=0, inst_valid_o=0, inst_o=0, pc_o=0.
REQ-033 Reset asserted mid-operation SHALL abandon any outstanding request. The memory is reset by the same rst, so no stale response follows.

Verification
REQ-034 Reset release, gnt=1, rvalid one cycle after grant with 32'h0000_0093, ready=1 -> req at addr 0x0, inst_valid_o with inst_o=0x00000093, pc_o=0x0, next req at 0x4, fetch_count_o=1.
REQ-035 Hold ready=0 for 5 cycles in S_HOLD -> inst_o/pc_o stable, no new request, count unchanged.
REQ-036 Redirect to 0x103 in S_WAIT, then rvalid with 0xDEADBEEF -> response dropped, next req at 0x100, later inst_valid_o with pc_o=0x100.
REQ-037 Redirect to 0x40 on the same cycle as grant of 0x8 -> 0x8 response discarded, next req at 0x40.
REQ-038 Fetch from 0xFFFFFFFC, consumed -> next req at 0x00000000.
REQ-039 Assert rst during S_HOLD -> immediately inst_valid_o=0, fetch_count_o=0. After release, req at RESET_PC.
